// File: rtl/adxl345_level_display.sv
// Selects one accelerometer axis, smooths it with a power-of-two moving average
// and shows the resulting signed tilt level (-4..+4) on a centre-zero 8-LED bar.
module adxl345_level_display #(
    parameter int AVG_LOG2 = 2,
    parameter int SHIFT    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] x_data,
    input  logic [15:0] y_data,
    input  logic [15:0] z_data,
    input  logic [2:0]  SW,
    output logic [7:0]  led_8bitOutput,
    output logic [3:0]  level,
    output logic        level_valid
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int ACC_W  = 16 + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [2:0]                sw_meta;
    logic [2:0]                sw_sync;
    logic [2:0]                sw_prev;
    logic signed [15:0]        ring [DEPTH];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic [AVG_LOG2-1:0]       wptr;
    logic [FILL_W-1:0]         fill;
    logic                      qual_d;
    logic                      flush;
    logic                      sel_valid;
    logic                      accept;
    logic                      window_full_next;
    logic signed [15:0]        sel_data;
    logic signed [15:0]        oldest;
    logic signed [15:0]        avg;
    logic signed [15:0]        raw;
    logic signed [3:0]         level_calc;

    // Centre-zero bar: positive levels grow upward from led[4], negative downward from led[3].
    function automatic logic [7:0] bar_of(input logic signed [3:0] lv);
        logic [7:0] b;
        int         n;
        b = 8'h00;
        n = int'(lv);
        for (int i = 0; i < 4; i++) begin
            if (n > i)  b[4+i] = 1'b1;
            if (n < -i) b[3-i] = 1'b1;
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= 3'b000;
            sw_sync <= 3'b000;
            sw_prev <= 3'b000;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
        end
    end

    assign flush     = (sw_sync != sw_prev);
    assign sel_valid = (sw_sync == 3'b001) || (sw_sync == 3'b010) || (sw_sync == 3'b100);
    assign accept    = sample_valid && sel_valid && !flush;

    always_comb begin
        sel_data = 16'sd0;
        case (sw_sync)
            3'b001:  sel_data = x_data;
            3'b010:  sel_data = y_data;
            3'b100:  sel_data = z_data;
            default: sel_data = 16'sd0;
        endcase
    end

    // While the window is still filling there is no oldest entry to retire.
    assign oldest           = (fill == FILL_W'(DEPTH)) ? ring[wptr] : 16'sd0;
    assign acc_next         = acc + {{AVG_LOG2{sel_data[15]}}, sel_data}
                                  - {{AVG_LOG2{oldest[15]}}, oldest};
    assign window_full_next = (fill >= FILL_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= 16'sd0;
            acc    <= '0;
            wptr   <= '0;
            fill   <= '0;
            qual_d <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= 16'sd0;
            acc    <= '0;
            wptr   <= '0;
            fill   <= '0;
            qual_d <= 1'b0;
        end else begin
            qual_d <= accept && window_full_next;
            if (accept) begin
                ring[wptr] <= sel_data;
                acc        <= acc_next;
                wptr       <= wptr + AVG_LOG2'(1);
                if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
            end
        end
    end

    assign avg = 16'(acc >>> AVG_LOG2);
    assign raw = avg >>> SHIFT;

    always_comb begin
        level_calc = raw[3:0];
        if (raw > 16'sd4)       level_calc = 4'sd4;
        else if (raw < -16'sd4) level_calc = -4'sd4;
    end

    // Stage 2 reads the accumulator left behind by the previous accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_8bitOutput <= 8'h00;
            level          <= 4'h0;
            level_valid    <= 1'b0;
        end else if (flush) begin
            led_8bitOutput <= 8'h00;
            level          <= 4'h0;
            level_valid    <= 1'b0;
        end else if (!sel_valid) begin
            led_8bitOutput <= 8'h81;
            level          <= 4'h0;
            level_valid    <= 1'b0;
        end else if (qual_d) begin
            led_8bitOutput <= bar_of(level_calc);
            level          <= level_calc;
            level_valid    <= 1'b1;
        end else begin
            level_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adxl345_level_display.sv
// Bench for adxl345_level_display: directed scenarios plus randomized traffic,
// all checked against a window-queue reference model.
module tb_adxl345_level_display;

    localparam int AVG_LOG2 = 2;
    localparam int SHIFT    = 5;
    localparam int D        = 1 << AVG_LOG2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] x_data = 16'h0000;
    logic [15:0] y_data = 16'h0000;
    logic [15:0] z_data = 16'h0000;
    logic [2:0]  SW = 3'b001;
    logic [7:0]  led_8bitOutput;
    logic [3:0]  level;
    logic        level_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int       win[$];
    bit       pend = 1'b0;
    logic [2:0] m_meta = 3'b000;
    logic [2:0] m_sync = 3'b000;
    logic [2:0] m_prev = 3'b000;
    int       exp_led = 0;
    int       exp_lvl = 0;
    int       exp_vld = 0;

    adxl345_level_display #(.AVG_LOG2(AVG_LOG2), .SHIFT(SHIFT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .x_data         (x_data),
        .y_data         (y_data),
        .z_data         (z_data),
        .SW             (SW),
        .led_8bitOutput (led_8bitOutput),
        .level          (level),
        .level_valid    (level_valid)
    );

    always #5 clk = ~clk;

    function automatic int floorDiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int levelOf(input int sum);
        int a;
        int r;
        a = floorDiv(sum, D);
        r = floorDiv(a, 1 << SHIFT);
        if (r > 4)  r = 4;
        if (r < -4) r = -4;
        return r;
    endfunction

    function automatic int barOf(input int n);
        if (n > 0) return ((1 << n) - 1) << 4;
        if (n < 0) return (8'hF0 >> (-n)) & 8'h0F;
        return 0;
    endfunction

    // Reference: a plain queue of the last D accepted samples, summed when needed.
    always @(posedge clk or negedge reset_n) begin
        bit fl;
        bit ok;
        int v;
        int sum;
        if (!reset_n) begin
            win.delete();
            pend = 1'b0;
            m_meta = 3'b000; m_sync = 3'b000; m_prev = 3'b000;
            exp_led = 0; exp_lvl = 0; exp_vld = 0;
        end else begin
            fl = (m_sync != m_prev);
            ok = $onehot(m_sync);
            if (fl) begin
                exp_led = 0; exp_lvl = 0; exp_vld = 0;
            end else if (!ok) begin
                exp_led = 8'h81; exp_lvl = 0; exp_vld = 0;
            end else if (pend) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                exp_lvl = levelOf(sum);
                exp_led = barOf(exp_lvl);
                exp_vld = 1;
            end else begin
                exp_vld = 0;
            end
            pend = 1'b0;
            if (fl) begin
                win.delete();
            end else if (sample_valid && ok) begin
                v = (m_sync == 3'b001) ? int'($signed(x_data)) :
                    (m_sync == 3'b010) ? int'($signed(y_data)) : int'($signed(z_data));
                win.push_back(v);
                if (win.size() > D) void'(win.pop_front());
                pend = (win.size() == D);
            end
            m_prev = m_sync;
            m_sync = m_meta;
            m_meta = SW;
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            checkOutput("model_led", led_8bitOutput, exp_led);
            checkOutput("model_level", $signed(level), exp_lvl);
            checkOutput("model_valid", level_valid, exp_vld);
        end
    end

    task automatic applyStimulus(input logic [2:0] sw, input logic v,
                                 input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z);
        SW = sw;
        sample_valid = v;
        x_data = x;
        y_data = y;
        z_data = z;
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] sw, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(sw, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // One strobe plus one idle cycle; returns where the resulting level is visible.
    task automatic pulse(input logic [2:0] sw, input logic [15:0] val);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        x = sw[0] ? val : 16'($urandom);
        y = sw[1] ? val : 16'($urandom);
        z = sw[2] ? val : 16'($urandom);
        applyStimulus(sw, 1'b1, x, y, z);
        idle(sw, 1);
    endtask

    initial begin
        int lv_slide[4];
        int led_slide[4];
        logic [2:0] cur_sw;
        logic [15:0] rnd;
        lv_slide  = '{1, 1, 0, 0};
        led_slide = '{8'h10, 8'h10, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        checkOutput("reset_led", led_8bitOutput, 8'h00);
        checkOutput("reset_level", $signed(level), 0);
        checkOutput("reset_valid", level_valid, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        idle(3'b001, 6);

        for (int i = 0; i < 4; i++) begin
            pulse(3'b001, 16'h0040);
            checkOutput("fill_valid", level_valid, (i == 3) ? 1 : 0);
        end
        checkOutput("fill_level", $signed(level), 2);
        checkOutput("fill_led", led_8bitOutput, 8'h30);
        idle(3'b001, 1);
        checkOutput("fill_pulse_end", level_valid, 0);
        checkOutput("fill_hold_led", led_8bitOutput, 8'h30);

        for (int i = 0; i < 4; i++) begin
            pulse(3'b001, 16'h0000);
            checkOutput("slide_valid", level_valid, 1);
            checkOutput("slide_level", $signed(level), lv_slide[i]);
            checkOutput("slide_led", led_8bitOutput, led_slide[i]);
        end

        pulse(3'b001, 16'h0040);
        pulse(3'b001, 16'h0040);
        idle(3'b010, 2);
        applyStimulus(3'b010, 1'b1, 16'h1234, 16'hFFF0, 16'h4321);
        checkOutput("flush_led", led_8bitOutput, 8'h00);
        checkOutput("flush_level", $signed(level), 0);
        idle(3'b010, 1);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b010, 16'hFFF0);
            checkOutput("neg_valid", level_valid, (i == 3) ? 1 : 0);
        end
        checkOutput("neg_level", $signed(level), -1);
        checkOutput("neg_led", led_8bitOutput, 8'h08);

        idle(3'b100, 3);
        for (int i = 0; i < 4; i++) pulse(3'b100, 16'h0100);
        checkOutput("sat_pos_level", $signed(level), 4);
        checkOutput("sat_pos_led", led_8bitOutput, 8'hF0);
        for (int i = 0; i < 4; i++) pulse(3'b100, 16'h8000);
        checkOutput("sat_neg_level", $signed(level), -4);
        checkOutput("sat_neg_led", led_8bitOutput, 8'h0F);

        idle(3'b011, 4);
        for (int i = 0; i < 6; i++) begin
            pulse(3'b011, 16'h0100);
            checkOutput("inv_valid", level_valid, 0);
            checkOutput("inv_led", led_8bitOutput, 8'h81);
            checkOutput("inv_level", $signed(level), 0);
        end

        idle(3'b001, 4);
        for (int i = 0; i < 4; i++) pulse(3'b001, 16'h0040);
        checkOutput("pre_rst_level", $signed(level), 2);
        applyStimulus(3'b001, 1'b1, 16'h0040, 16'h0, 16'h0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_led", led_8bitOutput, 8'h00);
        checkOutput("rst_level", $signed(level), 0);
        checkOutput("rst_valid", level_valid, 0);
        #47 reset_n = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        idle(3'b001, 6);
        for (int i = 0; i < 4; i++) begin
            pulse(3'b001, 16'h0040);
            checkOutput("post_rst_valid", level_valid, (i == 3) ? 1 : 0);
        end
        checkOutput("post_rst_level", $signed(level), 2);

        cur_sw = 3'b001;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 7))
                    0:       cur_sw = 3'($urandom);
                    1, 2:    cur_sw = 3'b001;
                    3, 4:    cur_sw = 3'b010;
                    default: cur_sw = 3'b100;
                endcase
            end
            if ($urandom_range(0, 3) == 0) rnd = 16'($urandom);
            else rnd = 16'(int'($urandom_range(0, 800)) - 400);
            applyStimulus(cur_sw, 1'($urandom_range(0, 1)),
                          cur_sw[0] ? rnd : 16'($urandom),
                          cur_sw[1] ? rnd : 16'($urandom),
                          cur_sw[2] ? rnd : 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
